// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data memory responder: load types, FSM states and
// the canonical right-justified byte-enable patterns.
package data_mem_responder_pkg;

   typedef enum logic [2:0] {
      LT_LB   = 3'b000,
      LT_LH   = 3'b001,
      LT_LW   = 3'b010,
      LT_LBU  = 3'b100,
      LT_LHU  = 3'b101,
      LT_NONE = 3'b111
   } load_type_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [3:0] BE_NONE = 4'b0000;
   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/data_mem_responder_load_align_extend.sv
// Load formatter: shifts the addressed lane down, then sign/zero-extends it.
// Misaligned halfword/word loads and unknown load types yield zero.
module load_align_extend
   import data_mem_responder_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  load_type,
   output logic [31:0] data,
   output logic        misalign
);

   logic [31:0] shifted;

   assign shifted = word >> {addr_lo, 3'b000};

   always_comb begin
      data     = 32'd0;
      misalign = 1'b0;
      case (load_type)
         LT_LB:  data = {{24{shifted[7]}}, shifted[7:0]};
         LT_LBU: data = {24'd0, shifted[7:0]};
         LT_LH: begin
            misalign = addr_lo[0];
            if (!addr_lo[0]) data = {{16{shifted[15]}}, shifted[15:0]};
         end
         LT_LHU: begin
            misalign = addr_lo[0];
            if (!addr_lo[0]) data = {16'd0, shifted[15:0]};
         end
         LT_LW: begin
            misalign = (addr_lo != 2'b00);
            if (addr_lo == 2'b00) data = shifted;
         end
         default: data = 32'd0;
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: accepts one load/store, stalls the pipeline for
// 1+WAIT_STATES cycles, then answers from a word-organised RAM in RESP.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_enable,
   input  logic        read_enable,
   input  logic [31:0] wr_addr,
   input  logic [31:0] read_addr,
   input  logic [31:0] wr_data,
   input  logic [3:0]  write_byte_enable,
   input  logic [2:0]  load_type,
   output logic [31:0] read_data,
   output logic        read_valid,
   output logic        mem_stall,
   output logic        mem_err
);

   localparam int          IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN      = 32'(4 * DEPTH_WORDS);
   localparam logic [2:0]  WAIT_LAST = 3'(WAIT_STATES);

   state_t      state_reg, state_next;
   logic [2:0]  wait_cnt_reg, wait_cnt_next;

   logic        op_write_reg, op_read_reg, dual_reg;
   logic [31:0] addr_reg, data_reg;
   logic [3:0]  be_reg;
   logic [2:0]  lt_reg;

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] rd_word_reg;

   logic        request, accept;
   logic [31:0] off, rd_off;
   logic        in_range;
   logic [IDX_W-1:0] wr_idx, rd_idx;
   logic [7:0]  be_wide;
   logic [31:0] data_sh;
   logic [3:0]  byte_we;
   logic        write_fire;
   logic [31:0] fmt_data;
   logic        misalign;

   assign request = wr_enable | read_enable;
   assign accept  = (state_reg == ST_IDLE) && request;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         wait_cnt_reg <= 3'd0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      mem_stall     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (request) begin
               mem_stall = 1'b1;
               if (WAIT_STATES > 0) begin
                  state_next    = ST_WAIT;
                  wait_cnt_next = 3'd1;
               end else begin
                  state_next = ST_RESP;
               end
            end
         end
         ST_WAIT: begin
            mem_stall = 1'b1;
            if (wait_cnt_reg == WAIT_LAST) begin
               state_next    = ST_RESP;
               wait_cnt_next = 3'd0;
            end else begin
               wait_cnt_next = wait_cnt_reg + 3'd1;
            end
         end
         ST_RESP: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // A simultaneous store wins; the load half of a dual request is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_write_reg <= 1'b0;
         op_read_reg  <= 1'b0;
         dual_reg     <= 1'b0;
         addr_reg     <= 32'd0;
         data_reg     <= 32'd0;
         be_reg       <= BE_NONE;
         lt_reg       <= LT_NONE;
      end else if (accept) begin
         op_write_reg <= wr_enable;
         op_read_reg  <= read_enable & ~wr_enable;
         dual_reg     <= wr_enable & read_enable;
         addr_reg     <= wr_enable ? wr_addr : read_addr;
         data_reg     <= wr_data;
         be_reg       <= write_byte_enable;
         lt_reg       <= load_type;
      end
   end

   assign off      = addr_reg - BASE_ADDR;
   assign in_range = (off < SPAN);
   assign wr_idx   = IDX_W'(off >> 2);

   // With zero wait states the RAM is read in the acceptance cycle itself,
   // so the read index comes straight from the port while idle.
   assign rd_off = ((state_reg == ST_IDLE) ? read_addr : addr_reg) - BASE_ADDR;
   assign rd_idx = IDX_W'(rd_off >> 2);

   assign be_wide    = {4'b0000, be_reg} << addr_reg[1:0];
   assign data_sh    = data_reg << {addr_reg[1:0], 3'b000};
   assign write_fire = (state_reg == ST_RESP) && op_write_reg && in_range;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_byte_we
         assign byte_we[gi] = write_fire & be_wide[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (byte_we[b]) mem[wr_idx][8*b +: 8] <= data_sh[8*b +: 8];
      end
      rd_word_reg <= mem[rd_idx];
   end

   load_align_extend u_align (
      .word      (rd_word_reg),
      .addr_lo   (addr_reg[1:0]),
      .load_type (lt_reg),
      .data      (fmt_data),
      .misalign  (misalign)
   );

   assign read_valid = (state_reg == ST_RESP) && op_read_reg;
   assign read_data  = (read_valid && in_range) ? fmt_data : 32'd0;
   assign mem_err    = (state_reg == ST_RESP) &&
                       (!in_range || dual_reg ||
                        (op_read_reg && misalign) ||
                        (op_write_reg && (|be_wide[7:4])));

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed table-driven bench for data_mem_responder (WAIT_STATES=1),
// plus hand-written back-to-back and reset-during-WAIT sequences.
module tb_data_mem_responder;

   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010,
                          LBU = 3'b100, LHU = 3'b101, LNONE = 3'b111;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_enable, read_enable;
   logic [31:0] wr_addr, read_addr, wr_data;
   logic [3:0]  write_byte_enable;
   logic [2:0]  load_type;
   logic [31:0] read_data;
   logic        read_valid, mem_stall, mem_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   data_mem_responder #(
      .DEPTH_WORDS (1024),
      .WAIT_STATES (1),
      .BASE_ADDR   (BASE)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .wr_enable         (wr_enable),
      .read_enable       (read_enable),
      .wr_addr           (wr_addr),
      .read_addr         (read_addr),
      .wr_data           (wr_data),
      .write_byte_enable (write_byte_enable),
      .load_type         (load_type),
      .read_data         (read_data),
      .read_valid        (read_valid),
      .mem_stall         (mem_stall),
      .mem_err           (mem_err)
   );

   typedef struct {
      logic        wr;
      logic        rd;
      logic [31:0] off;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [2:0]  lt;
      int          stalls;
      logic        valid;
      logic [31:0] data;
      logic        err;
   } vec_t;

   localparam int NV = 31;
   vec_t vecs[NV];

   function automatic vec_t mk(logic wr, logic rd, logic [31:0] off,
                               logic [31:0] wdata, logic [3:0] be, logic [2:0] lt,
                               logic valid, logic [31:0] data, logic err);
      vec_t v;
      v.wr = wr; v.rd = rd; v.off = off; v.wdata = wdata; v.be = be; v.lt = lt;
      v.stalls = 2; v.valid = valid; v.data = data; v.err = err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      wr_enable = 1'b0; read_enable = 1'b0;
      wr_addr = 32'd0; read_addr = 32'd0; wr_data = 32'd0;
      write_byte_enable = 4'd0; load_type = LNONE;
   endtask

   // Drives one request in IDLE and follows it to RESP (sampled at negedge+1).
   task automatic run_txn(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic [2:0] lt, output int stalls,
                          output logic v, output logic [31:0] d, output logic e,
                          output logic early);
      bit done = 0;
      @(negedge clk);
      wr_enable = wr; read_enable = rd; wr_addr = addr; read_addr = addr;
      wr_data = wdata; write_byte_enable = be; load_type = lt;
      #1;
      stalls = mem_stall ? 1 : 0;
      early = read_valid | mem_err;
      v = 1'b0; d = 32'd0; e = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         idle_inputs();
         #1;
         if (mem_stall) begin
            stalls++;
            early = early | read_valid | mem_err;
         end else begin
            v = read_valid; d = read_data; e = mem_err;
            done = 1;
         end
      end
      if (!done) begin
         failures++;
         $display("FAIL timeout waiting for RESP actual=stalled required=response");
      end
   endtask

   initial begin
      int          st;
      logic        v, e, early;
      logic [31:0] d;

      vecs[0]  = mk(1, 0, 32'h8,    32'hDEADBEEF, 4'hF, LNONE, 0, 32'h0,        0);
      vecs[1]  = mk(0, 1, 32'h8,    32'h0,        4'h0, LW,    1, 32'hDEADBEEF, 0);
      vecs[2]  = mk(1, 0, 32'h4,    32'h11223344, 4'hF, LNONE, 0, 32'h0,        0);
      vecs[3]  = mk(1, 0, 32'h5,    32'h00000080, 4'h1, LNONE, 0, 32'h0,        0);
      vecs[4]  = mk(0, 1, 32'h5,    32'h0,        4'h0, LB,    1, 32'hFFFFFF80, 0);
      vecs[5]  = mk(0, 1, 32'h5,    32'h0,        4'h0, LBU,   1, 32'h00000080, 0);
      vecs[6]  = mk(0, 1, 32'h4,    32'h0,        4'h0, LW,    1, 32'h11228044, 0);
      vecs[7]  = mk(1, 0, 32'h0,    32'h0,        4'hF, LNONE, 0, 32'h0,        0);
      vecs[8]  = mk(1, 0, 32'h2,    32'h00008001, 4'h3, LNONE, 0, 32'h0,        0);
      vecs[9]  = mk(0, 1, 32'h2,    32'h0,        4'h0, LH,    1, 32'hFFFF8001, 0);
      vecs[10] = mk(0, 1, 32'h2,    32'h0,        4'h0, LHU,   1, 32'h00008001, 0);
      vecs[11] = mk(0, 1, 32'h3,    32'h0,        4'h0, LH,    1, 32'h0,        1);
      vecs[12] = mk(0, 1, 32'h1,    32'h0,        4'h0, LW,    1, 32'h0,        1);
      vecs[13] = mk(0, 1, 32'h1000, 32'h0,        4'h0, LW,    1, 32'h0,        1);
      vecs[14] = mk(1, 0, 32'h1000, 32'h55555555, 4'hF, LNONE, 0, 32'h0,        1);
      vecs[15] = mk(0, 1, 32'h0,    32'h0,        4'h0, LW,    1, 32'h80010000, 0);
      vecs[16] = mk(0, 1, 32'hFFFFFFFC, 32'h0,    4'h0, LW,    1, 32'h0,        1);
      vecs[17] = mk(1, 1, 32'hC,    32'hCAFEF00D, 4'hF, LW,    0, 32'h0,        1);
      vecs[18] = mk(0, 1, 32'hC,    32'h0,        4'h0, LW,    1, 32'hCAFEF00D, 0);
      vecs[19] = mk(1, 0, 32'h3,    32'h0000ABCD, 4'h3, LNONE, 0, 32'h0,        1);
      vecs[20] = mk(0, 1, 32'h0,    32'h0,        4'h0, LW,    1, 32'hCD010000, 0);
      vecs[21] = mk(0, 1, 32'h8,    32'h0,        4'h0, LNONE, 1, 32'h0,        0);
      vecs[22] = mk(1, 0, 32'h8,    32'h00000012, 4'h0, LNONE, 0, 32'h0,        0);
      vecs[23] = mk(0, 1, 32'h8,    32'h0,        4'h0, LW,    1, 32'hDEADBEEF, 0);
      vecs[24] = mk(0, 1, 32'h8,    32'h0,        4'h0, LB,    1, 32'hFFFFFFEF, 0);
      vecs[25] = mk(0, 1, 32'h8,    32'h0,        4'h0, LH,    1, 32'hFFFFBEEF, 0);
      vecs[26] = mk(0, 1, 32'hA,    32'h0,        4'h0, LHU,   1, 32'h0000DEAD, 0);
      vecs[27] = mk(0, 1, 32'hB,    32'h0,        4'h0, LB,    1, 32'hFFFFFFDE, 0);
      vecs[28] = mk(1, 0, 32'hFFC,  32'h0BADF00D, 4'hF, LNONE, 0, 32'h0,        0);
      vecs[29] = mk(0, 1, 32'hFFC,  32'h0,        4'h0, LW,    1, 32'h0BADF00D, 0);
      vecs[30] = mk(0, 1, 32'h8,    32'h0,        4'h0, 3'b011, 1, 32'h0,       0);

      idle_inputs();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("reset stall", {31'd0, mem_stall}, 32'd0);
      chk("reset valid", {31'd0, read_valid}, 32'd0);
      chk("reset data", read_data, 32'd0);
      chk("reset err", {31'd0, mem_err}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         run_txn(vecs[i].wr, vecs[i].rd, BASE + vecs[i].off, vecs[i].wdata,
                 vecs[i].be, vecs[i].lt, st, v, d, e, early);
         $display("txn %0d wr=%0b rd=%0b off=%h lt=%b stalls=%0d valid=%0b data=%h err=%0b",
                  i, vecs[i].wr, vecs[i].rd, vecs[i].off, vecs[i].lt, st, v, d, e);
         chk($sformatf("row%0d stalls", i), st, vecs[i].stalls);
         chk($sformatf("row%0d early_out", i), {31'd0, early}, 32'd0);
         chk($sformatf("row%0d valid", i), {31'd0, v}, {31'd0, vecs[i].valid});
         chk($sformatf("row%0d data", i), d, vecs[i].data);
         chk($sformatf("row%0d err", i), {31'd0, e}, {31'd0, vecs[i].err});
      end

      // Back-to-back: request held high through RESP is not accepted until IDLE.
      @(negedge clk);
      read_enable = 1'b1; read_addr = BASE + 32'h8; load_type = LW;
      #1 chk("b2b accept stall", {31'd0, mem_stall}, 32'd1);
      @(negedge clk); #1 chk("b2b wait stall", {31'd0, mem_stall}, 32'd1);
      @(negedge clk); #1;
      chk("b2b resp stall", {31'd0, mem_stall}, 32'd0);
      chk("b2b resp valid", {31'd0, read_valid}, 32'd1);
      @(negedge clk); #1;
      chk("b2b second accept stall", {31'd0, mem_stall}, 32'd1);
      chk("b2b idle valid", {31'd0, read_valid}, 32'd0);
      @(negedge clk);
      idle_inputs();
      #1 chk("b2b second wait stall", {31'd0, mem_stall}, 32'd1);
      @(negedge clk); #1;
      chk("b2b second valid", {31'd0, read_valid}, 32'd1);
      chk("b2b second data", read_data, 32'hDEADBEEF);
      $display("txn b2b two LW @BASE+8 done");

      // Reset during WAIT discards the pending store.
      @(negedge clk);
      wr_enable = 1'b1; wr_addr = BASE + 32'h8; wr_data = 32'h99999999;
      write_byte_enable = 4'hF;
      @(negedge clk);
      idle_inputs();
      #1 chk("rst wait stall", {31'd0, mem_stall}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst mid stall", {31'd0, mem_stall}, 32'd0);
      chk("rst mid valid", {31'd0, read_valid}, 32'd0);
      chk("rst mid err", {31'd0, mem_err}, 32'd0);
      chk("rst mid data", read_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk); #1;
      chk("rst after valid", {31'd0, read_valid}, 32'd0);
      run_txn(1'b0, 1'b1, BASE + 32'h8, 32'd0, 4'd0, LW, st, v, d, e, early);
      $display("txn post-reset LW stalls=%0d valid=%0b data=%h err=%0b", st, v, d, e);
      chk("rst lost write data", d, 32'hDEADBEEF);
      chk("rst lost write valid", {31'd0, v}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
